// File: rtl/period_meter_if.sv
// Bundle of meas_clk stimulus and measurement results for period_meter.
// master drives the clock under test and controls; slave is the meter.
interface period_meter_if #(
  parameter int CNT_W = 32
) ();
  logic             meas_clk;
  logic             en;
  logic [31:0]      div_val;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             match;

  modport master (
    output meas_clk, en, div_val,
    input  period, high_time, valid, timeout, match
  );

  modport slave (
    input  meas_clk, en, div_val,
    output period, high_time, valid, timeout, match
  );
endinterface

// File: rtl/period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of meas_clk in clk_in cycles.
// Define PERIOD_MATCH_EN to compare results against div_val (match output); otherwise match is 0.
module period_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic          clk_in,
  input  logic          rst,
  period_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEASURE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lvl_d;
  logic                   lvl;
  logic                   rise;
  logic                   fall;
  logic                   expired;
  logic                   active;
  logic                   measuring;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hi_lat;

  assign lvl       = sync[SYNC_STAGES-1];
  assign rise      = lvl & ~lvl_d;
  assign fall      = ~lvl & lvl_d;
  // a rise on the same cycle as the limit is a valid edge, not a timeout
  assign expired   = (cnt == TO_VAL) && !rise;
  assign active    = (state != IDLE) && bus.en;
  assign measuring = (state == MEASURE) && bus.en;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      lvl_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], bus.meas_clk};
      lvl_d <= lvl;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.en) state_nxt = ARM;
        else        state_nxt = IDLE;
      end
      ARM: begin
        if (!bus.en)  state_nxt = IDLE;
        else if (rise) state_nxt = MEASURE;
        else          state_nxt = ARM;
      end
      MEASURE: begin
        if (!bus.en)      state_nxt = IDLE;
        else if (expired) state_nxt = ARM;
        else              state_nxt = MEASURE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hi_lat <= '0;
    end else if (state == IDLE) begin
      cnt    <= '0;
      hi_lat <= '0;
    end else begin
      if (rise)                cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (state == MEASURE && fall) hi_lat <= cnt;
    end
  end

  // results publish on the closing rise; timeout stays set until a full period completes
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      bus.period    <= '0;
      bus.high_time <= '0;
      bus.valid     <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (measuring && rise) begin
        bus.period    <= cnt;
        bus.high_time <= hi_lat;
        bus.valid     <= 1'b1;
        bus.timeout   <= 1'b0;
      end else if (active && expired) begin
        bus.timeout <= 1'b1;
      end
    end
  end

`ifdef PERIOD_MATCH_EN
  logic [CNT_W-1:0] div_full;
  logic [CNT_W-1:0] div_half;
  logic             div_ok;

  assign div_full = CNT_W'(bus.div_val);
  assign div_half = CNT_W'(bus.div_val >> 1);
  assign div_ok   = (bus.div_val >= 32'd2);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      bus.match <= 1'b0;
    end else if (state == IDLE || (active && expired)) begin
      bus.match <= 1'b0;
    end else if (measuring && rise) begin
      bus.match <= div_ok && (cnt == div_full) && (hi_lat == div_half);
    end
  end
`else
  assign bus.match = 1'b0;
`endif
endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: expected period/high time queued at each driven rise,
// checked against the valid strobe cycle-exactly; async stimulus checked by range.
module tb_period_meter;
  localparam int CW = 32;
  localparam int TO = 100;
`ifdef PERIOD_MATCH_EN
  localparam bit MATCH_ON = 1'b1;
`else
  localparam bit MATCH_ON = 1'b0;
`endif

  typedef struct {
    int per;
    int hi;
    int due;
    bit m;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t e;
  bit   have_rise   = 1'b0;
  int   last_rise   = 0;
  int   last_fall   = 0;
  bit   async_mode  = 1'b0;
  bit   async_run   = 1'b0;
  int   async_valid = 0;
  int   base;

  period_meter_if #(.CNT_W(CW)) bus ();

  period_meter #(.CNT_W(CW), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // one clk_in cycle of stimulus; rises while enabled queue the period they close
  task automatic drive(input bit v);
    exp_t x;
    @(posedge clk_in);
    #1;
    if (v && !bus.meas_clk && bus.en) begin
      if (have_rise) begin
        x.per = cyc - last_rise;
        x.hi  = last_fall - last_rise;
        x.due = cyc + 3;
        x.m   = MATCH_ON && (bus.div_val >= 32'd2) && (x.per == int'(bus.div_val))
                && (x.hi == int'(bus.div_val >> 1));
        q.push_back(x);
      end
      have_rise = 1'b1;
      last_rise = cyc;
    end
    if (!v && bus.meas_clk) last_fall = cyc;
    bus.meas_clk = v;
  endtask

  task automatic divider(input int n, input int h, input int periods);
    for (int p = 0; p < periods; p++)
      for (int i = 0; i < n; i++)
        drive(i < h);
  endtask

  always begin
    wait (async_run);
    bus.meas_clk = 1'b1;
    #186;
    bus.meas_clk = 1'b0;
    #187;
  end

  always @(negedge clk_in) begin
    if (!rst && bus.valid) begin
      if (async_mode) begin
        async_valid++;
        check_eq("async_period", (bus.period == 37 || bus.period == 38), 1);
        check_eq("async_high", (bus.high_time >= 17 && bus.high_time <= 20), 1);
        check_eq("async_match", bus.match, 0);
      end else if (q.size() == 0) begin
        check_eq("spurious_valid", bus.valid, 0);
      end else begin
        e = q.pop_front();
        check_eq("valid_cycle", cyc, e.due);
        check_eq("period", bus.period, e.per);
        check_eq("high_time", bus.high_time, e.hi);
        check_eq("match", bus.match, e.m);
        check_eq("timeout_at_valid", bus.timeout, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.meas_clk = 1'b0;
    bus.en       = 1'b0;
    bus.div_val  = 32'd0;
    @(negedge clk_in);
    check_eq("rst_period", bus.period, 0);
    check_eq("rst_high", bus.high_time, 0);
    check_eq("rst_valid", bus.valid, 0);
    check_eq("rst_timeout", bus.timeout, 0);
    check_eq("rst_match", bus.match, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst         = 1'b0;
    bus.en      = 1'b1;
    bus.div_val = 32'd4;
    drive(1'b0);
    drive(1'b0);

    // divide by 4, then by 5
    divider(4, 2, 6);
    bus.div_val = 32'd5;
    divider(5, 2, 6);

    // meas_clk stuck low: timeout 100 cycles after the last rise pulse
    base = last_rise;
    while (cyc < base + 106) begin
      @(negedge clk_in);
      if (cyc == base + 102) check_eq("timeout_early", bus.timeout, 0);
      if (cyc == base + 103) begin
        check_eq("timeout_set", bus.timeout, 1);
        check_eq("timeout_match", bus.match, 0);
      end
    end
    have_rise   = 1'b0;
    bus.div_val = 32'd4;
    divider(4, 2, 1);
    @(negedge clk_in);
    check_eq("timeout_sticky", bus.timeout, 1);
    divider(4, 2, 4);

    // enable dropped mid-period
    bus.div_val = 32'd8;
    divider(8, 4, 3);
    for (int i = 0; i < 6; i++) drive(i < 4);
    bus.en    = 1'b0;
    have_rise = 1'b0;
    divider(8, 4, 2);
    @(negedge clk_in);
    check_eq("idle_hold", bus.period, 8);
    for (int i = 0; i < 6; i++) drive(i < 4);
    bus.en = 1'b1;
    drive(1'b0);
    drive(1'b0);
    divider(8, 4, 4);

    // reset in the middle of a measurement
    bus.div_val = 32'd6;
    divider(6, 3, 3);
    for (int i = 0; i < 5; i++) drive(i < 3);
    check_eq("pre_rst_period", bus.period, 6);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_period", bus.period, 0);
    check_eq("mid_rst_high", bus.high_time, 0);
    check_eq("mid_rst_valid", bus.valid, 0);
    check_eq("mid_rst_timeout", bus.timeout, 0);
    check_eq("mid_rst_match", bus.match, 0);
    q.delete();
    have_rise = 1'b0;
    drive(1'b0);
    drive(1'b0);
    rst         = 1'b0;
    bus.div_val = 32'd4;
    drive(1'b0);
    divider(4, 2, 5);

    // free-running meas_clk at 37.3 clk_in cycles
    repeat (3) drive(1'b0);
    bus.en      = 1'b0;
    bus.div_val = 32'd0;
    check_eq("sync_drain", q.size(), 0);
    drive(1'b0);
    async_mode = 1'b1;
    bus.en     = 1'b1;
    async_run  = 1'b1;
    repeat (760) @(posedge clk_in);
    async_run = 1'b0;
    repeat (40) @(posedge clk_in);
    #1;
    bus.en = 1'b0;
    repeat (4) @(posedge clk_in);
    async_mode = 1'b0;
    check_eq("async_count", (async_valid >= 17), 1);
    check_eq("async_timeout", bus.timeout, 0);

    check_eq("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
